rsa_job_scheduler: RTL and testbench

Two-port round-robin scheduler that shares a single RSA encryption engine (modular exponentiation c = m^e mod n) between two requesters. It accepts a job from one requester, latches the operands, and issues a one-cycle start to the engine. It waits for the engine's finish pulse, then returns the ciphertext plus a measured engine-cycle count to the originating requester. It sits between the host-side clients and the engine and is the engine's sole driver.

---
 rtl/rsa_sched_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/rsa_job_scheduler.sv | 172 +++++++++++++++++
 tb/tb_rsa_job_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_sched_pkg.sv
// Shared types and constants for the RSA job scheduler.
package rsa_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // m^0 mod n is reported as 1 without running the engine.
    localparam int unsigned E_ZERO_RESULT = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
module rr_arbiter2
    import rsa_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       served_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    logic ptr_q;

    // Contention is settled by the pointer; a lone requester always wins.
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = (ptr_q == PORT1) ? 2'b10 : 2'b01;
        end
    end

    // Priority moves to the port that was not just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else if (advance_i) begin
            ptr_q <= ~served_i;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one modular-exponentiation engine between two requesters.
module rsa_job_scheduler
    import rsa_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CYC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2*WIDTH-1:0]   req0_m,
    input  logic [WIDTH-1:0]     req0_e,
    input  logic [2*WIDTH-1:0]   req0_n,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2*WIDTH-1:0]   req1_m,
    input  logic [WIDTH-1:0]     req1_e,
    input  logic [2*WIDTH-1:0]   req1_n,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_c,
    output logic [CYC_W-1:0]     rsp0_cycles,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_c,
    output logic [CYC_W-1:0]     rsp1_cycles,
    output logic                 eng_start,
    output logic [2*WIDTH-1:0]   eng_m,
    output logic [WIDTH-1:0]     eng_e,
    output logic [2*WIDTH-1:0]   eng_n,
    input  logic [2*WIDTH-1:0]   eng_c,
    input  logic                 eng_finish
);

    localparam int unsigned MW = 2 * WIDTH;
    localparam logic [CYC_W-1:0] CNT_ONE = CYC_W'(1);
    localparam logic [MW-1:0] C_EZERO = MW'(E_ZERO_RESULT);

    sched_state_e     state_q;
    logic             port_q;
    logic [MW-1:0]    m_q, n_q;
    logic [WIDTH-1:0] e_q;
    logic [CYC_W-1:0] cnt_q, cnt_inc;
    logic             eng_start_q;
    logic             rsp0_valid_q, rsp1_valid_q;
    logic [MW-1:0]    rsp0_c_q, rsp1_c_q;
    logic [CYC_W-1:0] rsp0_cycles_q, rsp1_cycles_q;

    logic [1:0]       req_vec, grant;
    logic             rr_ptr;
    logic             in_idle, accept, acc_port, rsp_hs;
    logic [MW-1:0]    acc_m, acc_n;
    logic [WIDTH-1:0] acc_e;
    logic             cap_en, cap_port;
    logic [MW-1:0]    cap_c;
    logic [CYC_W-1:0] cap_cyc;

    assign req_vec = {req1_valid, req0_valid};

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_vec),
        .advance_i (rsp_hs),
        .served_i  (port_q),
        .grant_o   (grant),
        .ptr_o     (rr_ptr)
    );

    assign in_idle    = (state_q == StIdle);
    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];
    assign accept     = req0_ready | req1_ready;
    assign acc_port   = grant[1] ? PORT1 : PORT0;
    assign acc_m      = (acc_port == PORT1) ? req1_m : req0_m;
    assign acc_e      = (acc_port == PORT1) ? req1_e : req0_e;
    assign acc_n      = (acc_port == PORT1) ? req1_n : req0_n;
    assign rsp_hs     = (state_q == StResp) & ((port_q == PORT1) ? rsp1_ready : rsp0_ready);
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    // A result lands either straight from IDLE (e == 0) or from the engine in WAIT.
    assign cap_en   = (accept & (acc_e == '0)) | ((state_q == StWait) & eng_finish);
    assign cap_port = in_idle ? acc_port : port_q;
    assign cap_c    = in_idle ? C_EZERO : eng_c;
    assign cap_cyc  = in_idle ? '0 : cnt_inc;

    // Job sequencing, engine handshake and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            port_q        <= PORT0;
            m_q           <= '0;
            e_q           <= '0;
            n_q           <= '0;
            cnt_q         <= '0;
            eng_start_q   <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_c_q      <= '0;
            rsp1_c_q      <= '0;
            rsp0_cycles_q <= '0;
            rsp1_cycles_q <= '0;
        end else begin
            eng_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        port_q <= acc_port;
                        m_q    <= acc_m;
                        e_q    <= acc_e;
                        n_q    <= acc_n;
                        if (acc_e == '0) begin
                            state_q <= StResp;
                        end else begin
                            state_q     <= StIssue;
                            eng_start_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_inc;
                    if (eng_finish) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_hs) begin
                        state_q      <= StIdle;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (cap_en) begin
                if (cap_port == PORT1) begin
                    rsp1_valid_q  <= 1'b1;
                    rsp1_c_q      <= cap_c;
                    rsp1_cycles_q <= cap_cyc;
                end else begin
                    rsp0_valid_q  <= 1'b1;
                    rsp0_c_q      <= cap_c;
                    rsp0_cycles_q <= cap_cyc;
                end
            end
        end
    end

    // Under contention the grant must follow the priority pointer.
    always_ff @(posedge clk) begin
        if (rst_n && in_idle && (req_vec == 2'b11)) begin
            assert (grant[rr_ptr]);
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_m       = m_q;
    assign eng_e       = e_q;
    assign eng_n       = n_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_c      = rsp0_c_q;
    assign rsp1_c      = rsp1_c_q;
    assign rsp0_cycles = rsp0_cycles_q;
    assign rsp1_cycles = rsp1_cycles_q;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Bench for rsa_job_scheduler: behavioural engine plus job-level scoreboard.
module tb_rsa_job_scheduler;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CYC_W = 16;
    localparam int unsigned CYC_S = 3;
    localparam int unsigned MW    = 2 * WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [MW-1:0]     req0_m, req0_n, req1_m, req1_n;
    logic [WIDTH-1:0]  req0_e, req1_e;
    logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [MW-1:0]     rsp0_c, rsp1_c;
    logic [CYC_W-1:0]  rsp0_cycles, rsp1_cycles;
    logic              eng_start, eng_finish;
    logic [MW-1:0]     eng_m, eng_n, eng_c;
    logic [WIDTH-1:0]  eng_e;

    logic              s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_eng_start;
    logic [MW-1:0]     s_rsp0_c, s_rsp1_c, s_eng_m, s_eng_n;
    logic [CYC_S-1:0]  s_rsp0_cycles, s_rsp1_cycles;
    logic [WIDTH-1:0]  s_eng_e;

    rsa_job_scheduler #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_e(req0_e),
        .req0_n(req0_n),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_e(req1_e),
        .req1_n(req1_n),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
        .rsp0_cycles(rsp0_cycles),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
        .rsp1_cycles(rsp1_cycles),
        .eng_start(eng_start), .eng_m(eng_m), .eng_e(eng_e), .eng_n(eng_n),
        .eng_c(eng_c), .eng_finish(eng_finish)
    );

    // Narrow-counter copy sharing every input; only its cycle count differs.
    rsa_job_scheduler #(.WIDTH(WIDTH), .CYC_W(CYC_S)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_m(req0_m), .req0_e(req0_e),
        .req0_n(req0_n),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_m(req1_m), .req1_e(req1_e),
        .req1_n(req1_n),
        .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(s_rsp0_c),
        .rsp0_cycles(s_rsp0_cycles),
        .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(s_rsp1_c),
        .rsp1_cycles(s_rsp1_cycles),
        .eng_start(s_eng_start), .eng_m(s_eng_m), .eng_e(s_eng_e), .eng_n(s_eng_n),
        .eng_c(eng_c), .eng_finish(eng_finish)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [MW-1:0] modexp(input logic [MW-1:0] m, input logic [WIDTH-1:0] e,
                                             input logic [MW-1:0] n);
        longint unsigned r, b, mm;
        mm = longint'(n);
        if (mm == 0) return '0;
        r = 1 % mm;
        b = longint'(m) % mm;
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return r[MW-1:0];
    endfunction

    // Behavioural engine: answers eng_lat cycles after its start pulse.
    int eng_lat = 10;
    int stray_tok = 0;
    int stray_seen = 0;
    int n_starts = 0;
    bit eng_busy = 0;
    int eng_done = 0;
    logic [MW-1:0] eng_res;

    initial begin
        eng_finish = 1'b0;
        eng_c = '0;
        forever begin
            @(posedge clk);
            #2;
            eng_finish = 1'b0;
            if (!rst_n) begin
                eng_busy = 0;
            end else begin
                if (stray_tok != stray_seen) begin
                    stray_seen = stray_tok;
                    eng_finish = 1'b1;
                    eng_c = 16'hbeef;
                end
                if (eng_busy && cyc == eng_done) begin
                    eng_finish = 1'b1;
                    eng_c = eng_res;
                    eng_busy = 0;
                end
                if (eng_start) begin
                    n_starts++;
                    eng_busy = 1;
                    eng_done = cyc + eng_lat;
                    eng_res = modexp(eng_m, eng_e, eng_n);
                end
            end
        end
    end

    // Stimulus policy and job-level reference model.
    bit            pend [2];
    logic [MW-1:0] pm [2];
    logic [MW-1:0] pn [2];
    logic [WIDTH-1:0] pe [2];
    int gen_pct = 0, jobs_left = 0, rdy_mode = 0, lat_mode = 0;

    bit busy = 0, ptr = 0, cur_port = 0, cur_eng = 0;
    logic [MW-1:0] cur_c, cur_m, cur_n;
    logic [WIDTH-1:0] cur_e;
    int cur_lat = 0, acc_cyc = 0, due_cyc = 0, vcnt = 0, jobs_done = 0;
    logic [MW-1:0] last_c [2];
    int grant_log[$];

    task automatic set_req(input int k, input int m, input int e, input int n);
        pend[k] = 1;
        pm[k] = MW'(m);
        pe[k] = WIDTH'(e);
        pn[k] = MW'(n);
    endtask

    task automatic step();
        bit exp_v, r0, r1, w, acc, st;
        int lat;
        logic [MW-1:0] oc;
        logic [CYC_W-1:0] ocy;
        logic [CYC_S-1:0] ocs;
        @(posedge clk);
        #3;
        for (int k = 0; k < 2; k++) begin
            if (!pend[k] && jobs_left > 0 && $urandom_range(0, 99) < gen_pct) begin
                jobs_left--;
                set_req(k, $urandom_range(0, 65535),
                        ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255),
                        $urandom_range(1, 65535));
            end
        end
        req0_valid = pend[0]; req0_m = pm[0]; req0_e = pe[0]; req0_n = pn[0];
        req1_valid = pend[1]; req1_m = pm[1]; req1_e = pe[1]; req1_n = pn[1];
        exp_v = busy && (cyc >= due_cyc);
        case (rdy_mode)
            0: begin r0 = 1; r1 = 1; end
            1: begin r0 = ($urandom_range(0, 2) != 0); r1 = ($urandom_range(0, 2) != 0); end
            default: begin r0 = (vcnt >= 5); r1 = r0; end
        endcase
        rsp0_ready = r0;
        rsp1_ready = r1;
        #1;
        acc = 0;
        w = 0;
        if (!busy && (pend[0] || pend[1])) begin
            acc = 1;
            w = (pend[0] && pend[1]) ? ptr : pend[1];
        end
        check("req0_ready", req0_ready, acc && !w);
        check("req1_ready", req1_ready, acc && w);
        check("s_req0_ready", s_req0_ready, acc && !w);
        check("s_req1_ready", s_req1_ready, acc && w);
        st = busy && cur_eng && (cyc == acc_cyc + 1);
        check("eng_start", eng_start, st);
        check("s_eng_start", s_eng_start, st);
        if (st) begin
            check("eng_m", eng_m, cur_m);
            check("eng_e", eng_e, cur_e);
            check("eng_n", eng_n, cur_n);
            check("s_eng_ops", {s_eng_m, s_eng_e, s_eng_n}, {cur_m, cur_e, cur_n});
        end
        check("rsp0_valid", rsp0_valid, exp_v && !cur_port);
        check("rsp1_valid", rsp1_valid, exp_v && cur_port);
        check("s_rsp0_valid", s_rsp0_valid, exp_v && !cur_port);
        check("s_rsp1_valid", s_rsp1_valid, exp_v && cur_port);
        if (exp_v) begin
            oc  = cur_port ? rsp1_c : rsp0_c;
            ocy = cur_port ? rsp1_cycles : rsp0_cycles;
            ocs = cur_port ? s_rsp1_cycles : s_rsp0_cycles;
            check("rsp_c", oc, cur_c);
            check("rsp_cycles", ocy, cur_lat);
            check("s_rsp_c", cur_port ? s_rsp1_c : s_rsp0_c, cur_c);
            check("s_rsp_cycles_sat", ocs, (cur_lat > 7) ? 7 : cur_lat);
            vcnt++;
            if (cur_port ? r1 : r0) begin
                busy = 0;
                ptr = !cur_port;
                jobs_done++;
                last_c[cur_port] = oc;
                vcnt = 0;
            end
        end
        if (acc) begin
            lat = (lat_mode == 0) ? 10 : (lat_mode == 2) ? 20 : $urandom_range(1, 15);
            busy = 1;
            cur_port = w;
            acc_cyc = cyc;
            cur_m = pm[w];
            cur_e = pe[w];
            cur_n = pn[w];
            cur_eng = (pe[w] != 0);
            if (cur_eng) begin
                cur_lat = lat;
                cur_c = modexp(pm[w], pe[w], pn[w]);
                due_cyc = cyc + lat + 2;
                eng_lat = lat;
            end else begin
                cur_lat = 0;
                cur_c = MW'(1);
                due_cyc = cyc + 1;
            end
            pend[w] = 0;
            grant_log.push_back(int'(w));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        req0_valid = 0;
        req1_valid = 0;
        rsp0_ready = 0;
        rsp1_ready = 0;
        pend[0] = 0;
        pend[1] = 0;
        @(posedge clk);
        #3;
        rst_n = 1;
        busy = 0;
        ptr = 0;
        vcnt = 0;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
        check({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid, s_rsp0_valid, s_rsp1_valid}, 4'b0);
        check({tag, "_eng_start"}, eng_start, 1'b0);
        check({tag, "_rsp_c"}, {rsp0_c, rsp1_c}, '0);
        check({tag, "_rsp_cycles"}, {rsp0_cycles, rsp1_cycles}, '0);
        check({tag, "_eng_ops"}, {eng_m, eng_e, eng_n}, '0);
    endtask

    task automatic run_until(input string tag, input int target, input int bound);
        for (int i = 0; i < bound && jobs_done < target; i++) step();
        check({tag, "_done"}, jobs_done, target);
    endtask

    initial begin
        int starts0, base;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_m = '0; req0_e = '0; req0_n = '0;
        req1_m = '0; req1_e = '0; req1_n = '0;
        pend[0] = 0; pend[1] = 0;

        do_reset();
        check_reset_state("reset");

        // Both ports request in the first cycle: port 0 (engine job) then port 1 (e == 0).
        set_req(0, 5, 3, 33);
        set_req(1, 7, 0, 33);
        lat_mode = 0;
        rdy_mode = 0;
        starts0 = n_starts;
        grant_log.delete();
        run_until("first", 2, 100);
        check("first_grant_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("first_grant0", grant_log[0], 0);
            check("first_grant1", grant_log[1], 1);
        end
        check("first_c0", last_c[0], 26);
        check("first_c1", last_c[1], 1);
        check("first_engine_starts", n_starts - starts0, 1);

        // Both held valid continuously: grants must alternate.
        grant_log.delete();
        gen_pct = 100;
        jobs_left = 4;
        lat_mode = 1;
        base = jobs_done;
        run_until("alt", base + 4, 200);
        check("alt_grant_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) check("alt_grant", grant_log[i], i % 2);

        // Stalled responses while the other port waits.
        gen_pct = 0;
        set_req(0, 9, 7, 101);
        set_req(1, 3, 4, 55);
        rdy_mode = 2;
        lat_mode = 0;
        base = jobs_done;
        run_until("stall", base + 2, 200);

        // Reset during WAIT, then a stray finish pulse.
        rdy_mode = 0;
        lat_mode = 2;
        set_req(0, 11, 13, 200);
        for (int i = 0; i < 50 && !(busy && cyc >= acc_cyc + 4); i++) step();
        check("midreset_reached_wait", busy, 1'b1);
        do_reset();
        check_reset_state("midreset");
        stray_tok++;
        for (int i = 0; i < 6; i++) step();
        lat_mode = 0;
        set_req(0, 2, 5, 35);
        base = jobs_done;
        run_until("post_reset", base + 1, 100);
        check("post_reset_c0", last_c[0], 32);

        // Randomised traffic.
        gen_pct = 30;
        jobs_left = 40;
        rdy_mode = 1;
        lat_mode = 1;
        base = jobs_done;
        run_until("random", base + 40, 4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
